// File: rtl/dmux_lane_collector_pkg.sv
// Shared constants and types for the round-robin lane collector.
// Optional feature macro used by the collector: DMUX_COLLECT_FLUSH_EN.
package dmux_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned SEL_W = 2;

    // FILL: accepting beats into lanes; FULL: presenting a word downstream.
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } coll_state_e;

endpackage

// File: rtl/dmux_lane_collector_if.sv
// Handshake/bus bundle between a beat producer/word consumer and the collector.
// The flush signal exists only when DMUX_COLLECT_FLUSH_EN is defined.
interface dmux_lane_collector_if #(
    parameter int unsigned DATA_W = 1
);
    import dmux_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       data_in;
    logic [SEL_W-1:0]        sel_out;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out;
    logic [LANES-1:0]        lane_mask;
`ifdef DMUX_COLLECT_FLUSH_EN
    logic                    flush;
`endif

    // Environment side: offers beats, consumes words.
    modport master (
`ifdef DMUX_COLLECT_FLUSH_EN
        output flush,
`endif
        output in_valid, data_in, out_ready,
        input  in_ready, sel_out, out_valid, out, lane_mask
    );

    // Collector side.
    modport slave (
`ifdef DMUX_COLLECT_FLUSH_EN
        input  flush,
`endif
        input  in_valid, data_in, out_ready,
        output in_ready, sel_out, out_valid, out, lane_mask
    );

endinterface

// File: rtl/dmux_lane_collector_dmux.sv
// 1:4 demultiplexer: routes the single data_in bit to the output named by sel.
// Used by the collector as a one-hot lane write-enable decoder.
module dmux
    import dmux_pkg::*;
(
    input  logic             data_in,
    input  logic [SEL_W-1:0] sel,
    output logic [LANES-1:0] out
);

    // One-hot decode of sel, gated by data_in.
    always_comb begin
        out      = '0;
        out[sel] = data_in;
    end

endmodule

// File: rtl/dmux_lane_collector.sv
// Round-robin lane collector: steers serial beats into lanes 0..3 and
// presents a full 4-lane word over a valid/ready handshake.
// Optional feature: DMUX_COLLECT_FLUSH_EN adds a flush input that emits a
// partial word, with unwritten lanes read as zero.
module dmux_lane_collector
    import dmux_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    dmux_lane_collector_if.slave bus
);

    coll_state_e       state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [LANES-1:0]  mask_q, mask_d;
    logic [DATA_W-1:0] lane_q [LANES];

    logic              in_ready;
    logic              out_valid;
    logic              in_fire;
    logic              out_fire;
    logic              flush_go;
    logic [LANES-1:0]  we;

    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = out_valid & bus.out_ready;

`ifdef DMUX_COLLECT_FLUSH_EN
    // A flush only matters if something is (or is about to be) in the lanes;
    // it is ignored in FULL by the state decode below.
    assign flush_go = bus.flush & ((sel_q != '0) | in_fire);
`else
    assign flush_go = 1'b0;
`endif

    dmux u_dmux (
        .data_in (in_fire),
        .sel     (sel_q),
        .out     (we)
    );

    // State, lane pointer and occupancy mask registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            sel_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            mask_q  <= mask_d;
        end
    end

    // Lane data registers, written by the one-hot enables; not cleared on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned n = 0; n < LANES; n++) begin
                lane_q[n] <= '0;
            end
        end else begin
            for (int unsigned n = 0; n < LANES; n++) begin
                if (we[n]) begin
                    lane_q[n] <= bus.data_in;
                end
            end
        end
    end

    // Next-state, pointer and mask decode.
    // In FULL the pointer sits at 0, so a beat accepted in the draining cycle
    // is decoded straight into lane 0 and the new mask is just the enable.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        mask_d  = mask_q;
        unique case (state_q)
            FILL: begin
                if (in_fire) begin
                    mask_d = mask_q | we;
                    sel_d  = sel_q + 1'b1;
                    if (sel_q == SEL_W'(LANES - 1)) begin
                        state_d = FULL;
                    end
                end
                if (flush_go) begin
                    state_d = FULL;
                    sel_d   = '0;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = FILL;
                    mask_d  = we;
                    sel_d   = in_fire ? SEL_W'(1) : '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Handshake outputs; in_ready follows out_ready only while FULL.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        if (state_q == FULL) begin
            out_valid = 1'b1;
            in_ready  = bus.out_ready;
        end
    end

    // Word assembly from registered lanes; unwritten lanes read as zero.
    always_comb begin
        bus.out = '0;
        for (int unsigned n = 0; n < LANES; n++) begin
            bus.out[n*DATA_W +: DATA_W] = mask_q[n] ? lane_q[n] : '0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sel_out   = sel_q;
    assign bus.lane_mask = mask_q;

endmodule
